// File: rtl/activity_pkg.sv
// Shared state encoding and default timing for the activity LED stretcher.
package activity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int DEF_CW         = 22;
    localparam int DEF_ON_CYCLES  = 2**21;
    localparam int DEF_OFF_CYCLES = 2**21;
    localparam int DEF_EW         = 16;

endpackage

// File: rtl/activity_sync2.sv
// Two-flop synchronizer for a single bit from a foreign clock domain.
// Latency 2 clocks; no backpressure.
module activity_sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/activity_led.sv
// activity_led: stretches trigger pulses into LED blinks; ACTIVITY_LED_SYNC_EN adds a 2-flop input sync.
// Latency 1 clk (3 with sync); no backpressure, triggers during a blink fold into one further blink.
module activity_led
    import activity_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int EW         = DEF_EW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          trigger,
    output logic          led,
    output logic          busy,
    output logic [EW-1:0] events
);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    logic trig;

`ifdef ACTIVITY_LED_SYNC_EN
    activity_sync2 u_sync (
        .clk  (clk),
        .rstn (rstn),
        .din  (trigger),
        .dout (trig)
    );
`else
    assign trig = trigger;
`endif

    state_t        state, state_nxt;
    logic [CW-1:0] timer, timer_nxt;
    logic          pending, pending_nxt;
    logic          led_nxt, busy_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            timer   <= '0;
            pending <= 1'b0;
            led     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            pending <= pending_nxt;
            led     <= led_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        pending_nxt = pending;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_nxt = ST_ON;
                    timer_nxt = ON_LOAD;
                end
            end
            ST_ON: begin
                pending_nxt = pending | trig;
                if (timer == '0) begin
                    state_nxt = ST_OFF;
                    timer_nxt = OFF_LOAD;
                end else begin
                    timer_nxt = timer - CW'(1);
                end
            end
            ST_OFF: begin
                if (timer == '0) begin
                    // The terminal dark cycle still counts as a trigger window.
                    if (pending || trig) begin
                        state_nxt = ST_ON;
                        timer_nxt = ON_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                    pending_nxt = 1'b0;
                end else begin
                    timer_nxt   = timer - CW'(1);
                    pending_nxt = pending | trig;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                timer_nxt   = '0;
                pending_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        led_nxt  = (state_nxt == ST_ON);
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            events <= '0;
        end else if (trig && (events != {EW{1'b1}})) begin
            events <= events + EW'(1);
        end
    end

endmodule

// File: tb/tb_activity_led.sv
module tb_activity_led;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int EW  = 4;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          trigger = 1'b0;
    logic          led;
    logic          busy;
    logic [EW-1:0] events;

    int total = 0;
    int bad   = 0;

    // Reference model: blink start edge plus period arithmetic.
    int cyc = 0;
    bit m_active = 0;
    int m_start = 0;
    bit m_pend = 0;
    int m_ev = 0;
    bit h1 = 0, h2 = 0;

    activity_led #(
        .CW         (3),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .EW         (EW)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .trigger (trigger),
        .led     (led),
        .busy    (busy),
        .events  (events)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 0;
        m_pend   = 0;
        m_ev     = 0;
        h1       = 0;
        h2       = 0;
    endtask

    task automatic model_edge(input bit t);
        bit eff;
`ifdef ACTIVITY_LED_SYNC_EN
        eff = h2;
        h2  = h1;
        h1  = t;
`else
        eff = t;
`endif
        cyc++;
        if (m_active && (cyc - m_start == ON + OFF)) begin
            if (m_pend || eff) begin
                m_start = cyc;
                m_pend  = 0;
            end else begin
                m_active = 0;
            end
        end else if (m_active) begin
            m_pend = m_pend | eff;
        end else if (eff) begin
            m_active = 1;
            m_start  = cyc;
            m_pend   = 0;
        end
        if (eff && m_ev < EMAX) m_ev++;
    endtask

    task automatic check(input string tag);
        logic          exp_led;
        logic          exp_busy;
        logic [EW-1:0] exp_ev;
        exp_led  = m_active && ((cyc - m_start) < ON);
        exp_busy = m_active;
        exp_ev   = EW'(m_ev);
        total++;
        assert (led === exp_led) else begin
            bad++;
            $error("FAIL %s led cyc=%0d got=%b want=%b", tag, cyc, led, exp_led);
        end
        total++;
        assert (busy === exp_busy) else begin
            bad++;
            $error("FAIL %s busy cyc=%0d got=%b want=%b", tag, cyc, busy, exp_busy);
        end
        total++;
        assert (events === exp_ev) else begin
            bad++;
            $error("FAIL %s events cyc=%0d got=%0d want=%0d", tag, cyc, events, exp_ev);
        end
    endtask

    task automatic step(input bit t, input string tag);
        @(negedge clk);
        trigger = t;
        @(posedge clk);
        model_edge(t);
        #1;
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            trigger = ~trigger;
            @(posedge clk);
            #1;
            check(tag);
        end
        @(negedge clk);
        trigger = 1'b0;
        rstn    = 1'b1;
    endtask

    initial begin
        do_reset("reset_hold");
        for (int i = 0; i < 3; i++) step(0, "post_reset_idle");

        // Single one-cycle pulse and the full blink that follows.
        step(1, "single");
        for (int i = 0; i < 9; i++) step(0, "single");

        // Second and third pulses during ON collapse into one extra blink.
        step(1, "pend_on");
        step(0, "pend_on");
        step(1, "pend_on");
        step(1, "pend_on");
        for (int i = 0; i < 14; i++) step(0, "pend_on");

        // Pulse on the terminal OFF cycle restarts immediately.
        step(1, "pend_last");
        for (int i = 0; i < 5; i++) step(0, "pend_last");
        step(1, "pend_last");
        for (int i = 0; i < 10; i++) step(0, "pend_last");

        // Continuous trigger: steady 111100 waveform, events saturate.
        for (int i = 0; i < 30; i++) step(1, "continuous");
        for (int i = 0; i < 10; i++) step(0, "continuous");

        do_reset("reset_again");

        // Asynchronous reset in the middle of ON.
        step(1, "async");
        step(0, "async");
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("async_drop");
        @(negedge clk);
        rstn = 1'b1;
        step(0, "async_idle");
        step(1, "async_reblink");
        for (int i = 0; i < 8; i++) step(0, "async_reblink");

        // Randomized traffic with varying density and occasional resets.
        for (int blk = 0; blk < 6; blk++) begin
            int dens;
            dens = $urandom_range(1, 6);
            for (int i = 0; i < 50; i++) begin
                step($urandom_range(0, 7) < dens, "random");
            end
            if ($urandom_range(0, 1) == 1) do_reset("random_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
